// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid
// buffer, synchronous flush, and fully registered handshake outputs.
module pipe_skid_reg #(
    parameter int unsigned   N       = 64,
    parameter logic [N-1:0]  RST_VAL = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    localparam int unsigned CNT_W = 2;

    // State encoding equals occupancy so count is a direct image of the state.
    typedef enum logic [CNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       main_data_q, main_data_d;
    logic [N-1:0]       skid_data_q, skid_data_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept_c;
    logic               drain_c;

    assign accept_c = in_valid & in_ready_q;
    assign drain_c  = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Squash everything; data registers keep stale contents.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (accept_c && drain_c) begin
                        main_data_d = in_data;
                    end else if (accept_c) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                    end else if (drain_c) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain_c) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Handshake outputs are precomputed from next state so they leave flops.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
        count_d     = CNT_W'(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= RST_VAL;
            skid_data_q <= RST_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboarded checks for pipe_skid_reg (N=8, non-zero RST_VAL).
module tb_pipe_skid_reg;

    localparam int unsigned N       = 8;
    localparam logic [N-1:0] RST_V  = 8'h5A;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   count;

    int unsigned  n_checks;
    int unsigned  n_errors;

    pipe_skid_reg #(.N(N), .RST_VAL(RST_V)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic ov, input logic ir,
                               input logic [1:0] cnt);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
        check({tag, ".count"},     64'(count),     64'(cnt));
    endtask

    logic [N-1:0] q[$];
    logic         acc;
    logic         drn;
    logic         fl;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Async reset without any clock edge
        #1 rst = 1'b1;
        #1;
        check_state("reset", 1'b0, 1'b1, 2'd0);
        check("reset.out_data", 64'(out_data), 64'(RST_V));
        tick();
        #2 rst = 1'b0;

        // Streaming: one transfer per cycle, one cycle of latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = N'(i);
            tick();
            check_state("stream", 1'b1, 1'b1, 2'd1);
            check("stream.out_data", 64'(out_data), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check_state("stream_end", 1'b0, 1'b1, 2'd0);

        // Backpressure: fill both entries, hold, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0A;
        tick();
        check_state("bp1", 1'b1, 1'b1, 2'd1);
        check("bp1.out_data", 64'(out_data), 64'h0A);
        in_data = 8'h0B;
        tick();
        check_state("bp2", 1'b1, 1'b0, 2'd2);
        check("bp2.out_data", 64'(out_data), 64'h0A);
        in_data = 8'h0C;
        tick();
        check_state("bp_hold", 1'b1, 1'b0, 2'd2);
        check("bp_hold.out_data", 64'(out_data), 64'h0A);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_state("bp_drain1", 1'b1, 1'b1, 2'd1);
        check("bp_drain1.out_data", 64'(out_data), 64'h0B);
        tick();
        check_state("bp_drain2", 1'b0, 1'b1, 2'd0);
        out_ready = 1'b0;

        // Flush while full, with a pending input
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        check_state("fl_full", 1'b1, 1'b0, 2'd2);
        flush   = 1'b1;
        in_data = 8'h33;
        tick();
        flush = 1'b0;
        check_state("fl_after", 1'b0, 1'b1, 2'd0);
        in_data = 8'h44;
        tick();
        in_valid = 1'b0;
        check_state("fl_push", 1'b1, 1'b1, 2'd1);
        check("fl_push.out_data", 64'(out_data), 64'h44);

        // Flush in ONE with a real same-cycle accept that must be dropped
        in_valid = 1'b1;
        in_data  = 8'h55;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_state("fl_one", 1'b0, 1'b1, 2'd0);
        tick();
        check_state("fl_one_idle", 1'b0, 1'b1, 2'd0);

        // Random elastic traffic against a queue model
        q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = N'($urandom);
            fl  = flush;
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() > 0);
            tick();
            if (fl) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
            check("rnd.count",     64'(count),     64'(q.size()));
            check("rnd.in_ready",  64'(in_ready),  64'(q.size() < 2));
            check("rnd.out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) check("rnd.out_data", 64'(out_data), 64'(q[0]));
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset mid-cycle while full drops everything immediately
        in_valid = 1'b1;
        in_data  = 8'h71;
        tick();
        in_data = 8'h72;
        tick();
        in_valid = 1'b0;
        check_state("rst_full", 1'b1, 1'b0, 2'd2);
        #2 rst = 1'b1;
        #1;
        check_state("rst_mid", 1'b0, 1'b1, 2'd0);
        check("rst_mid.out_data", 64'(out_data), 64'(RST_V));
        tick();
        rst = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'h99;
        tick();
        in_valid = 1'b0;
        check_state("post_rst", 1'b1, 1'b1, 2'd1);
        check("post_rst.out_data", 64'(out_data), 64'h99);
        tick();
        check_state("post_rst_drain", 1'b0, 1'b1, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
